// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and defaults for the UART receive framer.
//   rx_state_e      : receive FSM state encoding (PARITY only reachable when
//                     UART_RX_PARITY_EN is defined)
//   DEF_CLK_PER_BIT : default clk cycles per UART bit
//   DEF_DATA_BITS   : default data bits per frame
package uart_pkg;

  localparam int unsigned DEF_CLK_PER_BIT = 434;
  localparam int unsigned DEF_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchroniser for the asynchronous rx line plus a
// falling-edge detector on the synchronised value.
//   clk        : system clock
//   reset      : synchronous, active-high; all flops reset to 1 (line idle)
//   rx_i       : asynchronous serial input
//   rx_sync_o  : synchronised rx
//   fall_o     : high for one cycle when synchronised rx goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync_o = sync_q;
  assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer -- UART receiver: start-bit qualification, mid-bit sampling,
// LSB-first data capture and stop-bit checking.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after
// the data bits and the parity_err output.
//   clk        : system clock (rising edge)
//   reset      : synchronous, active-high
//   rx         : asynchronous serial line, idles high
//   data_out   : last good received word, LSB = first bit on the line
//   valid      : one-cycle pulse, data_out updated this cycle
//   frame_err  : one-cycle pulse, stop bit sampled low
//   busy       : high whenever the FSM is not idle
//   parity_err : one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned TW = $clog2(CLK_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS + 1);

  // Half-bit load centres the start-bit sample; full-bit reloads keep every
  // later sample at the centre of its bit.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  logic rx_s;
  logic fall_s;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  // Set after a bad stop bit: hold off IDLE until the line returns high so a
  // held-low break reports only once.
  logic                 brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  logic timer_zero_s;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx),
    .rx_sync_o (rx_s),
    .fall_o    (fall_s)
  );

  assign timer_zero_s = (timer_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state, bit timing and output pulse generation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = brk_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (!timer_zero_s) begin
      timer_d = timer_q - TW'(1);
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      ST_IDLE: begin
        brk_d = 1'b0;
        if (fall_s) begin
          timer_d = HALF_LOAD;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (timer_zero_s) begin
          if (!rx_s) begin
            timer_d = FULL_LOAD;
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            // Start bit gone high again: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (timer_zero_s) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          timer_d = FULL_LOAD;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (timer_zero_s) begin
          // Even parity: data plus parity bit must hold an even count of ones.
          par_bad_d = ^{rx_s, shift_q};
          timer_d   = FULL_LOAD;
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif

      ST_STOP: begin
        if (brk_q) begin
          if (rx_s) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end else if (timer_zero_s) begin
          if (rx_s) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            brk_d   = 1'b1;
            state_d = ST_STOP;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer -- scoreboard bench for uart_rx_framer (CLK_PER_BIT=16,
// DATA_BITS=8). Stimulus tasks push the expected response of each frame;
// a monitor pops and compares whenever the DUT raises a pulse.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx_framer;

  localparam int C = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx;
  logic [D-1:0] data_out;
  logic         valid;
  logic         frame_err;
  logic         busy;
  logic         perr_s;
`ifdef UART_RX_PARITY_EN
  logic         parity_err;
  assign perr_s = parity_err;
`else
  assign perr_s = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_framer #(.CLK_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // kind: 0 = valid, 1 = frame_err, 2 = parity_err
  typedef struct {
    int           kind;
    logic [D-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [D-1:0] last_good = '0;
  logic         prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (valid || frame_err || perr_s) begin
      check("exclusive", int'(valid) + int'(frame_err) + int'(perr_s), 1);
      check("pulse_width", prev_pulse, 0);
      k = valid ? 0 : (frame_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got kind %0d data %0h expected no pulse at %0t", k, data_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", k, e.kind);
        check("data_out", data_out, e.data);
      end
    end
    prev_pulse = valid || frame_err || perr_s;
  end

  // Drive one frame and push what the receiver must report for it.
  // stop=0 keeps the line low for brk_len extra cycles after the stop bit.
  task automatic send_frame(input logic [D-1:0] d, input logic stop,
                            input logic par_ok, input int brk_len);
    exp_t e;
    if (!stop) begin
      e.kind = 1;
      e.data = last_good;
`ifdef UART_RX_PARITY_EN
    end else if (!par_ok) begin
      e.kind = 2;
      e.data = last_good;
`endif
    end else begin
      e.kind = 0;
      e.data = d;
      last_good = d;
    end
    exp_q.push_back(e);

    rx = 1'b0;
    hold(C);
    for (int i = 0; i < D; i++) begin
      rx = d[i];
      hold(C);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_ok ? (^d) : ~(^d);
    hold(C);
`endif
    rx = stop;
    hold(C);
    if (!stop) begin
      hold(brk_len);
      check("busy_in_break", busy, 1);
      rx = 1'b1;
      hold(4);
      check("busy_after_break", busy, 0);
    end
    check("pulse_seen", exp_q.size(), 0);
  endtask

  initial begin
    logic [D-1:0] rd;
    logic         rstop;
    logic         rpar;
    logic [7:0]   pat55;

    reset = 1'b1;
    rx    = 1'b1;
    hold(4);
    check("rst_data_out", data_out, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_parity_err", perr_s, 0);
    reset = 1'b0;
    hold(4);

    // Single good frame.
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    hold(2);
    check("a5_data", data_out, 8'hA5);
    check("a5_busy", busy, 0);

    // Short low glitch in IDLE must be rejected.
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(8);
    check("glitch_busy", busy, 0);
    hold(C);

    // Bad stop bit with a long break: one frame_err, data_out unchanged.
    send_frame(8'h3C, 1'b0, 1'b1, 100);
    check("break_data", data_out, 8'hA5);
    hold(C);

    // Back-to-back frames, no idle gap.
    send_frame(8'h01, 1'b1, 1'b1, 0);
    check("b2b_first", data_out, 8'h01);
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    check("b2b_second", data_out, 8'hFF);
    hold(C);

    // Reset in the middle of data bit 4 of 0x55.
    pat55 = 8'h55;
    rx = 1'b0;
    hold(C);
    for (int i = 0; i < 4; i++) begin
      rx = pat55[i];
      hold(C);
    end
    rx = pat55[4];
    hold(C / 2);
    reset = 1'b1;
    hold(2);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ferr", frame_err, 0);
    last_good = '0;
    reset = 1'b0;
    rx    = 1'b1;
    hold(4 * C);
    send_frame(8'h12, 1'b1, 1'b1, 0);
    check("after_rst_data", data_out, 8'h12);
    hold(C);

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07 needs parity bit 1.
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("par_bad_data", data_out, 8'h12);
    hold(C);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_ok_data", data_out, 8'h07);
    hold(C);
`endif

    // Randomised frames with gaps, glitches, breaks and parity faults.
    for (int n = 0; n < 24; n++) begin
      rd    = D'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      rpar  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        rx = 1'b0;
        hold($urandom_range(1, 5));
        rx = 1'b1;
        hold(C);
      end
      send_frame(rd, rstop, rpar, $urandom_range(C, 4 * C));
      hold($urandom_range(0, 2 * C));
    end

    hold(2 * C);
    check("final_busy", busy, 0);
    check("final_data", data_out, last_good);
    check("leftover_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
